// File: rtl/mdr_fetch_ctrl.sv
// Fetches 1-4 consecutive bytes from memory and feeds them to the MDR as a load/shift stream.
// Latency: 4 cycles per byte with zero wait states (REQ, WAIT, LOAD, SHIFT/DONE); first mem_rd the cycle after start.
// Backpressure: stalls in WAIT until mem_ready, gives up after TIMEOUT cycles; start is ignored while busy.
module mdr_fetch_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [1:0]        nbytes,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mdr_data,
  output logic              mdr_re,
  output logic              mdr_shift,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] TO_LIM = TIMEOUT[3:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [2:0]        rem_q, rem_nxt;
  logic [3:0]        tcnt_q, tcnt_nxt;
  logic [3:0]        tcnt_inc;
  logic [DATA_W-1:0] mdr_q, mdr_nxt;
  logic              err_q, err_nxt;

  assign tcnt_inc = tcnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      tcnt_q <= '0;
      mdr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      rem_q  <= rem_nxt;
      tcnt_q <= tcnt_nxt;
      mdr_q  <= mdr_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    tcnt_nxt  = tcnt_q;
    mdr_nxt   = mdr_q;
    err_nxt   = err_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          addr_nxt  = addr_in;
          rem_nxt   = {1'b0, nbytes} + 3'd1;
          err_nxt   = 1'b0;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        tcnt_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A ready on the last allowed cycle still wins over the timeout.
        if (mem_ready) begin
          mdr_nxt   = mem_data;
          state_nxt = S_LOAD;
        end else begin
          tcnt_nxt = tcnt_inc;
          if (tcnt_inc == TO_LIM) begin
            err_nxt   = 1'b1;
            state_nxt = S_ERR;
          end
        end
      end
      S_LOAD: begin
        rem_nxt   = rem_q - 3'd1;
        state_nxt = (rem_q > 3'd1) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        addr_nxt  = addr_q + 1'b1;
        state_nxt = S_REQ;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are pure decodes of the state register, so they are one-hot by construction.
  assign mem_rd    = (state == S_REQ);
  assign mdr_re    = (state == S_LOAD);
  assign mdr_shift = (state == S_SHIFT);
  assign done      = (state == S_DONE) || (state == S_ERR);
  assign busy      = (state != S_IDLE);
  assign mem_addr  = addr_q;
  assign mdr_data  = mdr_q;
  assign err       = err_q;

endmodule
